// File: rtl/inst_dispatch_if.sv
// inst_dispatch_if: bundle between the dispatcher and its instruction source / load / writeback controllers
// master: dispatcher view (drives launches, decoded fields, busy, inst_cnt)
// slave:  environment view (drives inst_empty, instruct, ilc_done, w2c_done)
// DISPATCH_TIMEOUT_EN adds the sticky timeout_err signal.
interface inst_dispatch_if #(
   parameter int INST_LEN   = 128,
   parameter int ADDR_LEN_D = 9,
   parameter int X_MAC      = 4
);
   logic                        inst_empty;
   logic                        inst_req;
   logic [INST_LEN-1:0]         instruct;
   logic                        ilc_start;
   logic [ADDR_LEN_D*X_MAC-1:0] ilc_st_addr;
   logic                        ilc_ispad;
   logic [8:0]                  ilc_linelen;
   logic                        ilc_done;
   logic [3:0]                  bsr_iszero;
   logic [7:0]                  bsr_buffermux;
   logic                        pec_fromfifo;
   logic                        pec_tofifo;
   logic                        w2c_start;
   logic [ADDR_LEN_D*X_MAC-1:0] w2c_st_addr;
   logic [8:0]                  w2c_linelen;
   logic                        w2c_pooled;
   logic                        pooled_type;
   logic [8:0]                  wb_st_rd_addr;
   logic [3:0]                  w2c_shift_len;
   logic [1:0]                  w2c_valid_mac;
   logic                        w2c_done;
   logic                        busy;
   logic [15:0]                 inst_cnt;
`ifdef DISPATCH_TIMEOUT_EN
   logic                        timeout_err;
`endif
   modport master (
`ifdef DISPATCH_TIMEOUT_EN
      output timeout_err,
`endif
      input  inst_empty, instruct, ilc_done, w2c_done,
      output inst_req, ilc_start, ilc_st_addr, ilc_ispad, ilc_linelen, bsr_iszero, bsr_buffermux,
             pec_fromfifo, pec_tofifo, w2c_start, w2c_st_addr, w2c_linelen, w2c_pooled, pooled_type,
             wb_st_rd_addr, w2c_shift_len, w2c_valid_mac, busy, inst_cnt
   );
   modport slave (
`ifdef DISPATCH_TIMEOUT_EN
      input  timeout_err,
`endif
      output inst_empty, instruct, ilc_done, w2c_done,
      input  inst_req, ilc_start, ilc_st_addr, ilc_ispad, ilc_linelen, bsr_iszero, bsr_buffermux,
             pec_fromfifo, pec_tofifo, w2c_start, w2c_st_addr, w2c_linelen, w2c_pooled, pooled_type,
             wb_st_rd_addr, w2c_shift_len, w2c_valid_mac, busy, inst_cnt
   );
endinterface

// File: rtl/inst_dispatch.sv
// inst_dispatch: pops one instruction word at a time, latches its fields and runs load then writeback.
// Ports: clk; rst (synchronous, active-high); bus (inst_dispatch_if.master) carrying the instruction
// source handshake, load/writeback launches and completions, decoded field outputs, busy and inst_cnt.
// Optional macro DISPATCH_TIMEOUT_EN: TO_W-bit watchdog in the RUN states with sticky bus.timeout_err.
module inst_dispatch #(
   parameter int INST_LEN   = 128,
   parameter int ADDR_LEN_D = 9,
   parameter int X_MAC      = 4,
   parameter int TO_W       = 16
) (
   input logic             clk,
   input logic             rst,
   inst_dispatch_if.master bus
);
   localparam int AW = ADDR_LEN_D * X_MAC;
   typedef enum logic [2:0] {IDLE, FETCH, LATCH, ILC_RUN, W2C_RUN} state_t;
   state_t state;
   logic   w2c_back;
   logic   ilc_pend;
   logic   unused_bits;
`ifdef DISPATCH_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;
`endif
   assign unused_bits = ^bus.instruct[INST_LEN-1:123];
   assign bus.busy = (state != IDLE);
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         w2c_back           <= 1'b0;
         ilc_pend           <= 1'b0;
         bus.inst_req       <= 1'b0;
         bus.ilc_start      <= 1'b0;
         bus.ilc_st_addr    <= '0;
         bus.ilc_ispad      <= 1'b0;
         bus.ilc_linelen    <= '0;
         bus.bsr_iszero     <= '0;
         bus.bsr_buffermux  <= 8'b11100100;
         bus.pec_fromfifo   <= 1'b0;
         bus.pec_tofifo     <= 1'b1;
         bus.w2c_start      <= 1'b0;
         bus.w2c_st_addr    <= '0;
         bus.w2c_linelen    <= '0;
         bus.w2c_pooled     <= 1'b0;
         bus.pooled_type    <= 1'b0;
         bus.wb_st_rd_addr  <= '0;
         bus.w2c_shift_len  <= '0;
         bus.w2c_valid_mac  <= '0;
         bus.inst_cnt       <= '0;
`ifdef DISPATCH_TIMEOUT_EN
         to_cnt             <= '0;
         bus.timeout_err    <= 1'b0;
`endif
      end else begin
         bus.inst_req  <= 1'b0;
         bus.ilc_start <= 1'b0;
         bus.w2c_start <= 1'b0;
         case (state)
            IDLE: if (!bus.inst_empty) begin
               bus.inst_req <= 1'b1;
               state        <= FETCH;
            end
            FETCH: state <= LATCH;
            LATCH: begin
               bus.ilc_st_addr   <= bus.instruct[AW-1:0];
               bus.ilc_ispad     <= bus.instruct[36];
               bus.ilc_linelen   <= bus.instruct[45:37];
               bus.bsr_iszero    <= bus.instruct[49:46];
               bus.bsr_buffermux <= bus.instruct[57:50];
               bus.pec_fromfifo  <= bus.instruct[58];
               bus.pec_tofifo    <= bus.instruct[59];
               w2c_back          <= bus.instruct[60];
               bus.w2c_st_addr   <= bus.instruct[61 +: AW];
               bus.w2c_linelen   <= bus.instruct[105:97];
               bus.w2c_pooled    <= bus.instruct[106];
               bus.pooled_type   <= bus.instruct[107];
               bus.wb_st_rd_addr <= bus.instruct[116:108];
               bus.w2c_shift_len <= bus.instruct[120:117];
               bus.w2c_valid_mac <= bus.instruct[122:121];
               if (bus.instruct[45:37] != '0) begin
                  state    <= ILC_RUN;
                  ilc_pend <= 1'b1;
               end else if (bus.instruct[60]) begin
                  state         <= W2C_RUN;
                  bus.w2c_start <= 1'b1;
               end else begin
                  state        <= IDLE;
                  bus.inst_cnt <= bus.inst_cnt + 1'b1;
               end
            end
            // The load launch fires on the cycle after entry, once the latched fields are on the outputs.
            ILC_RUN: begin
               ilc_pend      <= 1'b0;
               bus.ilc_start <= ilc_pend;
               if (bus.ilc_done) begin
                  if (w2c_back) begin
                     state         <= W2C_RUN;
                     bus.w2c_start <= 1'b1;
                  end else begin
                     state        <= IDLE;
                     bus.inst_cnt <= bus.inst_cnt + 1'b1;
                  end
               end
            end
            W2C_RUN: if (bus.w2c_done) begin
               state        <= IDLE;
               bus.inst_cnt <= bus.inst_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
`ifdef DISPATCH_TIMEOUT_EN
         // Any exit from a RUN state restarts the count; expiry overrides the case above.
         if (!(state == ILC_RUN && !bus.ilc_done) && !(state == W2C_RUN && !bus.w2c_done))
            to_cnt <= '0;
         else if (to_cnt == '1) begin
            state           <= IDLE;
            to_cnt          <= '0;
            ilc_pend        <= 1'b0;
            bus.ilc_start   <= 1'b0;
            bus.timeout_err <= 1'b1;
         end else
            to_cnt <= to_cnt + 1'b1;
`endif
      end
   end
endmodule

// File: tb/tb_inst_dispatch.sv
// tb_inst_dispatch: randomized self-checking bench for inst_dispatch against a timeline model of one instruction.
module tb_inst_dispatch;
   localparam int INST_LEN   = 128;
   localparam int ADDR_LEN_D = 9;
   localparam int X_MAC      = 4;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   int           n_chk = 0;
   int           n_fail = 0;
   logic [15:0]  exp_cnt = '0;
   logic [121:0] rst_fields;
   inst_dispatch_if #(.INST_LEN(INST_LEN), .ADDR_LEN_D(ADDR_LEN_D), .X_MAC(X_MAC)) bus ();
   inst_dispatch #(.INST_LEN(INST_LEN), .ADDR_LEN_D(ADDR_LEN_D), .X_MAC(X_MAC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
   function automatic logic [127:0] garbage();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction
   function automatic logic [127:0] rnd_word(input logic [8:0] ll, input logic wb);
      logic [127:0] w;
      w = garbage();
      w[45:37] = ll;
      w[60] = wb;
      return w;
   endfunction
   // Field map: every output field is the same-position slice of the word, with bit 60 (is_w2c_back) dropped.
   function automatic logic [121:0] decode(input logic [127:0] w);
      return {w[122:61], w[59:0]};
   endfunction
   function automatic logic [121:0] dut_fields();
      return {bus.w2c_valid_mac, bus.w2c_shift_len, bus.wb_st_rd_addr, bus.pooled_type, bus.w2c_pooled,
              bus.w2c_linelen, bus.w2c_st_addr, bus.pec_tofifo, bus.pec_fromfifo, bus.bsr_buffermux,
              bus.bsr_iszero, bus.ilc_linelen, bus.ilc_ispad, bus.ilc_st_addr};
   endfunction
   // Instruction source: offers a word, returns cycles until inst_req (99 = never), then presents w the cycle after.
   task automatic fetch(input logic [127:0] w, output int lat);
      bus.inst_empty = 1'b0;
      bus.instruct = garbage();
      lat = 99;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (bus.inst_req === 1'b1) begin
            lat = n;
            break;
         end
      end
      bus.inst_empty = 1'b1;
      if (lat == 99) return;
      @(posedge clk);
      #1;
      bus.instruct = w;
   endtask
   // Offsets relative to the inst_req cycle: load launch at +3, done l cycles later, writeback launch the cycle
   // after load done (or +2 with no load), writeback done m cycles after its launch, retire one cycle after done.
   task automatic run_inst(input logic [127:0] w, input int l, input int m);
      int lat, ilc_s, ilc_d, w2c_s, w2c_d, idle;
      logic [3:0] exp_ctl, got_ctl;
      fetch(w, lat);
      n_chk++;
      if (lat != 1) begin
         n_fail++;
         $display("FAIL req_latency: got %0d cycles, expected 1", lat);
         if (lat == 99) return;
      end
      ilc_s = (w[45:37] != 0) ? 3 : -1;
      ilc_d = (w[45:37] != 0) ? 3 + l : -1;
      w2c_s = w[60] ? ((ilc_d > 0) ? ilc_d + 1 : 2) : -1;
      w2c_d = w[60] ? w2c_s + m : -1;
      idle  = w[60] ? w2c_d + 1 : ((ilc_d > 0) ? ilc_d + 1 : 2);
      for (int o = 1; o <= idle; o++) begin
         @(negedge clk);
         exp_ctl = {o < idle, o == ilc_s, o == w2c_s, 1'b0};
         got_ctl = {bus.busy, bus.ilc_start, bus.w2c_start, bus.inst_req};
         n_chk++;
         if (got_ctl !== exp_ctl) begin
            n_fail++;
            $display("FAIL ctl@+%0d {busy,ilc_start,w2c_start,inst_req}: got %b expected %b", o, got_ctl, exp_ctl);
         end
         if (o >= 2) begin
            n_chk++;
            if (dut_fields() !== decode(w)) begin
               n_fail++;
               $display("FAIL fields@+%0d: got %h expected %h", o, dut_fields(), decode(w));
            end
            bus.instruct = garbage();
         end
         if (o == idle) begin
            exp_cnt++;
            n_chk++;
            if (bus.inst_cnt !== exp_cnt) begin
               n_fail++;
               $display("FAIL inst_cnt: got %0d expected %0d", bus.inst_cnt, exp_cnt);
            end
         end
         // Spurious done pulses land only where the matching RUN state is not active and must be ignored.
         bus.ilc_done = (o != idle) && ((o == ilc_d) || (($urandom_range(3) == 0) && !(o >= 2 && o <= ilc_d)));
         bus.w2c_done = (o != idle) && ((o == w2c_d) || (($urandom_range(3) == 0) && !(o >= w2c_s && o <= w2c_d)));
      end
      bus.ilc_done = 1'b0;
      bus.w2c_done = 1'b0;
   endtask
   task automatic test_reset();
      logic [3:0] got;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      got = {bus.busy, bus.ilc_start, bus.w2c_start, bus.inst_req};
      n_chk++;
      if (got !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b expected 0000", got);
      end
      n_chk++;
      if (dut_fields() !== rst_fields) begin
         n_fail++;
         $display("FAIL reset_fields: got %h expected %h", dut_fields(), rst_fields);
      end
      n_chk++;
      if (bus.inst_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %0d expected 0", bus.inst_cnt);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_chk++;
         if ({bus.busy, bus.inst_req, bus.bsr_buffermux, bus.pec_tofifo} !== {2'b00, 8'hE4, 1'b1}) begin
            n_fail++;
            $display("FAIL idle_empty[%0d] {busy,inst_req,buffermux,tofifo}: got %b%b %h %b expected 00 e4 1",
                     i, bus.busy, bus.inst_req, bus.bsr_buffermux, bus.pec_tofifo);
         end
      end
   endtask
   task automatic test_ilc_only();
      run_inst(rnd_word(9'd64, 1'b0), 10, 0);
   endtask
   task automatic test_ilc_w2c();
      logic [127:0] w;
      w = rnd_word(9'd64, 1'b1);
      w[105:97] = 9'd32;
      run_inst(w, $urandom_range(12, 1), $urandom_range(12, 1));
   endtask
   task automatic test_no_launch();
      run_inst(rnd_word(9'd0, 1'b0), 0, 0);
      run_inst(rnd_word(9'd0, 1'b0), 0, 0);
   endtask
   task automatic test_w2c_only();
      run_inst(rnd_word(9'd0, 1'b1), 0, $urandom_range(8, 1));
   endtask
   task automatic test_back_to_back();
      logic [8:0] ll;
      for (int i = 0; i < 30; i++) begin
         ll = ($urandom_range(2) == 0) ? 9'd0 : 9'($urandom_range(511, 1));
         run_inst(rnd_word(ll, 1'($urandom_range(1))), $urandom_range(6, 1), $urandom_range(6, 1));
      end
   endtask
   task automatic test_reset_mid();
      int lat;
      logic [3:0] got;
      fetch(rnd_word(9'd64, 1'b1), lat);
      n_chk++;
      if (lat != 1) begin
         n_fail++;
         $display("FAIL mid_req_latency: got %0d expected 1", lat);
      end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      bus.inst_empty = 1'b0;
      @(negedge clk);
      exp_cnt = '0;
      got = {bus.busy, bus.ilc_start, bus.w2c_start, bus.inst_req};
      n_chk++;
      if (got !== 4'b0) begin
         n_fail++;
         $display("FAIL mid_reset_ctl: got %b expected 0000", got);
      end
      n_chk++;
      if (bus.inst_cnt !== 16'd0 || dut_fields() !== rst_fields) begin
         n_fail++;
         $display("FAIL mid_reset_state: cnt %0d fields %h expected cnt 0 fields %h", bus.inst_cnt, dut_fields(), rst_fields);
      end
      rst = 1'b0;
      bus.inst_empty = 1'b1;
      bus.ilc_done = 1'b1;
      @(negedge clk);
      bus.ilc_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = {bus.busy, bus.ilc_start, bus.w2c_start, bus.inst_req};
         n_chk++;
         if (got !== 4'b0 || bus.inst_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL late_done[%0d]: ctl %b cnt %0d expected ctl 0000 cnt 0", i, got, bus.inst_cnt);
         end
      end
      run_inst(rnd_word(9'd5, 1'b1), 3, 2);
   endtask
   initial begin
      bus.inst_empty = 1'b1;
      bus.instruct = '0;
      bus.ilc_done = 1'b0;
      bus.w2c_done = 1'b0;
      rst_fields = '0;
      rst_fields[57:50] = 8'hE4;
      rst_fields[59] = 1'b1;
      test_reset();
      test_ilc_only();
      test_ilc_w2c();
      test_no_launch();
      test_w2c_only();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/inst_dispatch.md
INST_DISPATCH -- requirements
Module: inst_dispatch

Interface
REQ-001 Parameters SHALL be: INST_LEN, default 128, instruction word width; ADDR_LEN_D, default 9, per-MAC address width; X_MAC, default 4, MAC lanes; TO_W, default 16, timeout counter width.
REQ-002 Ports SHALL be: clk  in  1  sole clock; rst  in  1  synchronous, active-high reset.
REQ-003 Port: inst_empty  in  1  instruction source has no word.
REQ-004 Port: inst_req  out  1  one-cycle pop; the word is valid on instruct the cycle after.
REQ-005 Port: instruct  in  INST_LEN  instruction word.
REQ-006 Port: ilc_start  out  1  one-cycle load-controller launch.
REQ-007 Port: ilc_st_addr  out  ADDR_LEN_D*X_MAC  load start addresses.
REQ-008 Port: ilc_ispad  out  1  pad flag.
REQ-009 Port: ilc_linelen  out  9  load line length.
REQ-010 Port: ilc_done  in  1  one-cycle load completion.
REQ-011 Port: bsr_iszero  out  4  lane-zero mask.
REQ-012 Port: bsr_buffermux  out  8  buffer select.
REQ-013 Port: pec_fromfifo  out  1  PE input from FIFO.
REQ-014 Port: pec_tofifo  out  1  PE output to FIFO.
REQ-015 Port: w2c_start  out  1  one-cycle writeback launch.
REQ-016 Port: w2c_st_addr  out  ADDR_LEN_D*X_MAC  writeback start addresses.
REQ-017 Port: w2c_linelen  out  9  writeback line length.
REQ-018 Port: w2c_pooled  out  1  pooling enable.
REQ-019 Port: pooled_type  out  1  pooling type.
REQ-020 Port: wb_st_rd_addr  out  9  writeback read address.
REQ-021 Port: w2c_shift_len  out  4  output shift.
REQ-022 Port: w2c_valid_mac  out  2  valid MAC count.
REQ-023 Port: w2c_done  in  1  one-cycle writeback completion.
REQ-024 Port: busy  out  1  high whenever the state is not IDLE.
REQ-025 Port: inst_cnt  out  16  retired-instruction count.

Function
REQ-026 Field decode SHALL be: [35:0] ilc_st_addr, [36] ispad, [45:37] ilc_linelen, [49:46] iszero, [57:50] buffermux, [58] fromfifo, [59] tofifo, [60] is_w2c_back, [96:61] w2c_st_addr, [105:97] w2c_linelen, [106] pooled, [107] pooled_type, [116:108] wb_st_rd_addr, [120:117] shift_len, [122:121] valid_mac.
REQ-027 FSM states SHALL be IDLE, FETCH, LATCH, ILC_RUN, W2C_RUN.
REQ-028 IDLE: when inst_empty=0, assert inst_req for exactly one cycle and go to FETCH; otherwise stay.
REQ-029 FETCH SHALL wait one cycle, then go to LATCH.
REQ-030 LATCH SHALL register all fields into output registers, which hold stable until the next LATCH.
REQ-031 From LATCH: if ilc_linelen!=0, pulse ilc_start the next cycle and enter ILC_RUN; else if is_w2c_back=1, go to W2C_RUN; else retire to IDLE.
REQ-032 ILC_RUN: on ilc_done, go to W2C_RUN if is_w2c_back=1, else retire to IDLE.
REQ-033 Entering W2C_RUN SHALL pulse w2c_start for one cycle; on w2c_done, retire to IDLE.
REQ-034 Retire SHALL increment inst_cnt by 1, wrapping from 0xFFFF to 0.
REQ-035 A done pulse outside its matching RUN state SHALL be ignored.
REQ-036 ilc_done and w2c_done asserted together in ILC_RUN: only ilc_done SHALL be acted on.
REQ-037 inst_req SHALL never be asserted outside IDLE; at most one instruction is in flight.

Reset
REQ-038 While rst=1 at a clk edge: state IDLE, all outputs 0, inst_cnt 0, except bsr_buffermux = 8'b11100100 and pec_tofifo = 1.
REQ-039 Reset mid-operation SHALL abort the instruction without retiring it and without asserting inst_req in that cycle.

Configuration
REQ-040 With DISPATCH_TIMEOUT_EN defined: a TO_W-bit counter SHALL run in ILC_RUN/W2C_RUN and clear on state change; at all-ones it SHALL force IDLE, set sticky output timeout_err (1 bit, cleared only by rst), and not increment inst_cnt.
REQ-041 Without DISPATCH_TIMEOUT_EN: no counter and no timeout_err port; RUN states wait indefinitely.

Verification
REQ-042 Reset, then inst_empty=1 for 20 cycles -> inst_req never high, busy=0, buffermux=0xE4, pec_tofifo=1.
REQ-043 Word with linelen=64, is_w2c_back=0; ilc_done 10 cycles after ilc_start -> inst_req at t, ilc_start at t+3, IDLE and inst_cnt=1 one cycle after ilc_done.
REQ-044 Word with linelen=64, is_w2c_back=1, w2c_linelen=32 -> w2c_start one cycle after ilc_done; w2c_linelen=32 stable until w2c_done; inst_cnt=1.
REQ-045 Word with linelen=0, is_w2c_back=0 -> no ilc_start or w2c_start, inst_cnt increments, next inst_req issued.
REQ-046 rst asserted during ILC_RUN -> IDLE next cycle, inst_cnt=0, a late ilc_done is ignored.
REQ-047 With DISPATCH_TIMEOUT_EN and TO_W=4, ilc_done withheld -> timeout_err=1 after 15 RUN cycles, IDLE, inst_cnt unchanged.
